// File: rtl/ram_io_responder.sv
// Byte-wide RAM + memory-mapped UART responder: RAM below 0x20000, IO at 0x30000-0x3FFFF, 1-cycle read latency.
// Optional SIM_HALT_EN macro enables the program_end pulse on writes to 0x30004.
module ram_io_responder #(
  parameter int ADDR_WIDTH   = 17,
  parameter int TX_DEPTH_LOG = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        cpu_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_end
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
  localparam int PW       = TX_DEPTH_LOG + 1;
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {TX_DEPTH_LOG{1'b0}}};

  logic [7:0] ram [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] tx_buf_q [0:TX_DEPTH-1];
  logic [7:0] tx_buf_d [0:TX_DEPTH-1];

  logic [18:0]   acc_q, acc_d;
  logic          first_q, first_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          tx_full_q, tx_full_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_full_q, rx_full_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [7:0]    mem_din_q, mem_din_d;

  logic [18:0] acc_key;
  logic [2:0]  io_off;
  logic        is_io, is_ram, acc_start;
  logic        tx_pop, tx_push_req, tx_push, rx_pop, rx_load;
  logic        unused_hi;

  assign acc_key   = {mem_a[17:0], mem_wr};
  assign io_off    = mem_a[2:0];
  assign is_io     = (mem_a[17:16] == 2'b11);
  assign is_ram    = !mem_a[17];
  assign unused_hi = ^mem_a[31:18];
  // IO side effects fire once per distinct access, however long it is held
  assign acc_start = first_q || (acc_key != acc_q);

  assign tx_valid = (wptr_q != rptr_q);
  assign tx_data  = tx_buf_q[rptr_q[TX_DEPTH_LOG-1:0]];
  assign cpu_rdy  = !tx_full_q;
  assign rx_ready = !rx_full_q;
  assign mem_din  = mem_din_q;

  always_comb begin
    acc_d       = acc_key;
    first_d     = 1'b0;
    tx_pop      = tx_valid && tx_ready;
    tx_push_req = acc_start && is_io && mem_wr && (io_off == 3'd0);
    tx_push     = tx_push_req && (!tx_full_q || tx_pop);
    wptr_d      = tx_push ? wptr_q + PW'(1) : wptr_q;
    rptr_d      = tx_pop  ? rptr_q + PW'(1) : rptr_q;
    tx_full_d   = ((wptr_d ^ rptr_d) == FULL_XOR);
    tx_ovf_d    = tx_ovf_q || (tx_push_req && !tx_push);
    tx_buf_d    = tx_buf_q;
    if (tx_push) tx_buf_d[wptr_q[TX_DEPTH_LOG-1:0]] = mem_dout;

    // A load is only possible while empty, so it never races a meaningful pop
    rx_pop    = acc_start && is_io && !mem_wr && (io_off == 3'd0);
    rx_load   = rx_valid && !rx_full_q;
    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (rx_load) begin
      rx_full_d = 1'b1;
      rx_byte_d = rx_data;
    end else if (rx_pop) begin
      rx_full_d = 1'b0;
    end

    mem_din_d = 8'h00;
    if (is_ram) begin
      mem_din_d = ram[mem_a[ADDR_WIDTH-1:0]];
    end else if (is_io) begin
      case (io_off)
        3'd0:    mem_din_d = rx_full_q ? rx_byte_q : 8'h00;
        3'd4:    mem_din_d = {5'b0, tx_ovf_q, rx_full_q, tx_full_q};
        default: mem_din_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_q     <= '0;
      first_q   <= 1'b1;
      wptr_q    <= '0;
      rptr_q    <= '0;
      tx_full_q <= 1'b0;
      tx_ovf_q  <= 1'b0;
      rx_full_q <= 1'b0;
      rx_byte_q <= 8'h00;
      mem_din_q <= 8'h00;
    end else begin
      acc_q     <= acc_d;
      first_q   <= first_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      tx_full_q <= tx_full_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_full_q <= rx_full_d;
      rx_byte_q <= rx_byte_d;
      mem_din_q <= mem_din_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by pointers and flags
  always_ff @(posedge clk_in) begin
    tx_buf_q <= tx_buf_d;
    if (mem_wr && is_ram) ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
  end

`ifdef SIM_HALT_EN
  logic program_end_q, program_end_d;

  always_comb begin
    program_end_d = acc_start && is_io && mem_wr && (io_off == 3'd4);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) program_end_q <= 1'b0;
    else        program_end_q <= program_end_d;
  end

  assign program_end = program_end_q;
`else
  assign program_end = 1'b0;
`endif

endmodule

// File: tb/tb_ram_io_responder.sv
// Bench for ram_io_responder: directed scenarios then random traffic against a queue-based reference model.
module tb_ram_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        cpu_rdy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_end;

`ifdef SIM_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  ram_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .cpu_rdy(cpu_rdy), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .program_end(program_end)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  ram_m [int];
  logic [7:0]  txq [$];
  bit          m_ovf, m_rxf, m_first;
  logic [7:0]  m_rxb;
  logic [18:0] m_prev;
  logic [7:0]  e_din;
  bit          e_pend;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the currently driven inputs, then compare
  task automatic tick();
    logic [17:0] a;
    logic [2:0]  off;
    bit          st, io;
    logic [7:0]  rd;
    a   = mem_a[17:0];
    off = a[2:0];
    io  = (a >= 18'h30000);
    if (rst_in) begin
      txq.delete();
      m_ovf = 0; m_rxf = 0; m_first = 1; e_din = 8'h00; e_pend = 0;
    end else begin
      st = m_first || ({a, mem_wr} != m_prev);
      rd = 8'h00;
      if (a < 18'h20000) rd = ram_m.exists(int'(a)) ? ram_m[int'(a)] : 8'h00;
      else if (io && off == 3'd0) rd = m_rxf ? m_rxb : 8'h00;
      else if (io && off == 3'd4) rd = {5'b0, m_ovf, m_rxf, (txq.size() == 8)};
      e_din = rd;
      if (txq.size() > 0 && tx_ready) void'(txq.pop_front());
      if (st && io && mem_wr && off == 3'd0) begin
        if (txq.size() < 8) txq.push_back(mem_dout);
        else m_ovf = 1;
      end
      if (rx_valid && !m_rxf) begin
        m_rxf = 1; m_rxb = rx_data;
      end else if (st && io && !mem_wr && off == 3'd0) begin
        m_rxf = 0;
      end
      if (mem_wr && a < 18'h20000) ram_m[int'(a)] = mem_dout;
      e_pend  = HALT_EN && st && io && mem_wr && off == 3'd4;
      m_first = 0;
      m_prev  = {a, mem_wr};
    end
    @(posedge clk_in);
    #1;
    chk("mem_din", mem_din, e_din);
    chk("tx_valid", {7'b0, tx_valid}, {7'b0, txq.size() > 0});
    if (txq.size() > 0) chk("tx_data", tx_data, txq[0]);
    chk("cpu_rdy", {7'b0, cpu_rdy}, {7'b0, txq.size() != 8});
    chk("rx_ready", {7'b0, rx_ready}, {7'b0, !m_rxf});
    chk("program_end", {7'b0, program_end}, {7'b0, e_pend});
  endtask

  task automatic acc(input logic [31:0] a, input logic wr, input logic [7:0] d, input int n);
    mem_a = a; mem_wr = wr; mem_dout = d;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic idle(input int n);
    acc(32'h0002_0000, 1'b0, 8'h00, n);
  endtask

  int pool [8] = '{32'h00000, 32'h00001, 32'h00123, 32'h0ABCD,
                   32'h10000, 32'h1FFFE, 32'h1FFFF, 32'h07777};

  initial begin
    int op, n;
    logic [31:0] a;
    rst_in = 1'b1; mem_a = 32'h0002_0000; mem_dout = 8'h00; mem_wr = 1'b0;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    tick(); tick();
    chk("reset_din", mem_din, 8'h00);
    chk("reset_cpu_rdy", {7'b0, cpu_rdy}, 8'h01);
    chk("reset_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("reset_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("reset_program_end", {7'b0, program_end}, 8'h00);
    rst_in = 1'b0;

    foreach (pool[i]) acc(pool[i], 1'b1, 8'($urandom), 1);

    // RAM write then read, and a hole read
    acc(32'h0000_0123, 1'b1, 8'hA5, 2);
    acc(32'h0000_0123, 1'b0, 8'h00, 1);
    chk("ram_read", mem_din, 8'hA5);
    acc(32'h0002_4000, 1'b0, 8'h00, 1);
    chk("hole_read", mem_din, 8'h00);

    // Held IO write pushes exactly once
    acc(32'h0003_0000, 1'b1, 8'h41, 2);
    idle(1);
    chk("held_push_data", tx_data, 8'h41);
    chk("held_push_valid", {7'b0, tx_valid}, 8'h01);
    tx_ready = 1'b1; idle(1); tx_ready = 1'b0;
    chk("drained", {7'b0, tx_valid}, 8'h00);

    // Fill the FIFO, overflow on the 9th push
    for (int i = 0; i < 9; i++) begin
      acc(32'h0003_0000, 1'b1, 8'(8'h10 + i), 1);
      if (i == 7) chk("full_cpu_rdy", {7'b0, cpu_rdy}, 8'h00);
      idle(1);
    end
    acc(32'h0003_0004, 1'b0, 8'h00, 1);
    chk("status_ovf_full", mem_din, 8'h05);
    tx_ready = 1'b1; idle(1); tx_ready = 1'b0;
    chk("cpu_rdy_after_pop", {7'b0, cpu_rdy}, 8'h01);

    // Refill, then push and pop in the same cycle while full
    acc(32'h0003_0000, 1'b1, 8'h20, 1);
    idle(1);
    for (int i = 1; i <= 4; i++) begin
      tx_ready = 1'b1;
      acc(32'h0003_0000, 1'b1, 8'(8'h20 + i), 1);
      tx_ready = 1'b0;
      chk("full_pushpop_cpu_rdy", {7'b0, cpu_rdy}, 8'h00);
      idle(1);
    end
    tx_ready = 1'b1; idle(10); tx_ready = 1'b0;

    // RX holding register
    rx_data = 8'h5A; rx_valid = 1'b1; idle(1); rx_valid = 1'b0;
    chk("rx_ready_low", {7'b0, rx_ready}, 8'h00);
    acc(32'h0003_0004, 1'b0, 8'h00, 1);
    chk("status_rx_full", {7'b0, mem_din[1]}, 8'h01);
    acc(32'h0003_0000, 1'b0, 8'h00, 1);
    chk("rx_read", mem_din, 8'h5A);
    tick();
    chk("rx_read_held", mem_din, 8'h00);
    idle(1);
    chk("rx_ready_high", {7'b0, rx_ready}, 8'h01);
    acc(32'h0003_0000, 1'b0, 8'h00, 1);
    chk("rx_read_empty", mem_din, 8'h00);

    // Halt port
    acc(32'h0003_0004, 1'b1, 8'h00, 1);
    chk("halt_pulse", {7'b0, program_end}, {7'b0, HALT_EN});
    tick();
    chk("halt_single", {7'b0, program_end}, 8'h00);
    idle(1);

    // Randomized traffic, with one reset in the middle
    for (int it = 0; it < 600; it++) begin
      if (it == 300) begin
        rst_in = 1'b1; mem_wr = 1'b0; tick(); rst_in = 1'b0;
      end
      op       = $urandom_range(0, 7);
      n        = $urandom_range(1, 3);
      tx_ready = ($urandom_range(0, 3) == 0);
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = 8'($urandom);
      a        = {14'($urandom), 18'h0};
      case (op)
        0: acc(a | pool[$urandom_range(0, 7)], 1'b1, 8'($urandom), n);
        1: acc(a | pool[$urandom_range(0, 7)], 1'b0, 8'h00, n);
        2: acc(a | 32'h2_0000 | 32'($urandom_range(0, 16'hFFFF)), 1'($urandom), 8'($urandom), n);
        3: acc(a | 32'h3_0000, 1'b1, 8'($urandom), n);
        4: acc(a | 32'h3_0000, 1'b0, 8'h00, n);
        5: acc(a | 32'h3_0004, 1'b0, 8'h00, n);
        6: acc(a | 32'h3_0000 | 32'($urandom_range(1, 3)) | (32'($urandom_range(0, 1)) << 2),
               1'($urandom), 8'($urandom), n);
        default: acc(a | 32'h3_0004, 1'b1, 8'($urandom), n);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
